// File: rtl/lut_loader_pkg.sv
// Shared types and sizing helpers for the serial LUT loader.
package lut_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LO,
    HI,
    END
  } state_t;

  function automatic int entries(input int in_width);
    return 1 << in_width;
  endfunction

  function automatic int table_bits(input int in_width, input int out_width);
    return entries(in_width) * out_width;
  endfunction

endpackage

// File: rtl/lut_serial_loader_if.sv
// Entry write handshake between the config source and the serial loader.
interface lut_serial_loader_if #(
  parameter int OUT_WIDTH = 3
) ();

  logic                 wr_valid;
  logic [OUT_WIDTH-1:0] wr_data;
  logic                 wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);

endinterface

// File: rtl/lut_bit_timer.sv
// Shift-clock phase timer: strobes phase_end on the last clk cycle of each
// CLK_DIV-long sclk phase while run is held.
module lut_bit_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic phase_end
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign phase_end = run && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear || !run || phase_end) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lut_serial_loader.sv
// Serial LUT-load transmitter: entries in over valid/ready, out MSB first on sd/sclk/scs_n.
// Optional frame cancel via abort/aborted when LUT_LOADER_ABORT_EN is defined.
module lut_serial_loader
  import lut_loader_pkg::*;
#(
  parameter int IN_WIDTH  = 3,
  parameter int OUT_WIDTH = 3,
  parameter int CLK_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lut_serial_loader_if.slave   wr,
  output logic                 busy,
  output logic                 done,
  output logic                 sclk,
  output logic                 sd,
  output logic                 scs_n
`ifdef LUT_LOADER_ABORT_EN
  ,
  input  logic                 abort,
  output logic                 aborted
`endif
);

  localparam int BW = $clog2(OUT_WIDTH) + 1;
  localparam int EW = IN_WIDTH + 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(OUT_WIDTH - 1);
  localparam logic [EW-1:0] ENT_TOTAL = EW'(entries(IN_WIDTH));

  state_t               state;
  state_t               next_state;
  logic [OUT_WIDTH-1:0] tx_shift;
  logic [BW-1:0]        bit_cnt;
  logic [EW-1:0]        entry_cnt;
  logic                 ready_q;
  logic                 run;
  logic                 phase_end;
  logic                 accept;
  logic                 abort_hit;
  logic                 last_bit;
  logic                 ready_d;
  logic                 sclk_d;
  logic                 scs_n_d;
  logic                 busy_d;
  logic                 done_d;

`ifdef LUT_LOADER_ABORT_EN
  logic aborted_d;
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // A cancel takes priority over a same-cycle handshake, so ready is masked combinationally.
  assign wr.wr_ready = ready_q && !abort_hit;
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign run         = (state == LO) || (state == HI) || (state == END);
  assign last_bit    = (bit_cnt == BIT_LAST);
  assign sd          = tx_shift[OUT_WIDTH-1];

  lut_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .clear     (abort_hit),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, WAIT: if (accept) next_state = LO;
      LO:         if (phase_end) next_state = HI;
      HI: begin
        if (phase_end) begin
          if (!last_bit) begin
            next_state = LO;
          end else if (entry_cnt == ENT_TOTAL) begin
            next_state = END;
          end else begin
            next_state = WAIT;
          end
        end
      end
      END:        if (phase_end) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
    if (abort_hit) begin
      next_state = IDLE;
    end
  end

  // Pins are decoded from the next state so they leave the chip straight from flops.
  always_comb begin
    ready_d = (next_state == IDLE) || (next_state == WAIT);
    sclk_d  = (next_state == HI);
    scs_n_d = (next_state == IDLE);
    busy_d  = (next_state != IDLE);
    done_d  = (state == END) && phase_end && !abort_hit;
`ifdef LUT_LOADER_ABORT_EN
    aborted_d = abort_hit;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
      sclk    <= 1'b0;
      scs_n   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef LUT_LOADER_ABORT_EN
      aborted <= 1'b0;
`endif
    end else begin
      ready_q <= ready_d;
      sclk    <= sclk_d;
      scs_n   <= scs_n_d;
      busy    <= busy_d;
      done    <= done_d;
`ifdef LUT_LOADER_ABORT_EN
      aborted <= aborted_d;
`endif
    end
  end

  // Zeros shift in behind each entry, so sd idles low once an entry is fully sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift  <= '0;
      bit_cnt   <= '0;
      entry_cnt <= '0;
    end else if (abort_hit) begin
      tx_shift  <= '0;
      bit_cnt   <= '0;
      entry_cnt <= '0;
    end else if (accept) begin
      tx_shift  <= wr.wr_data;
      bit_cnt   <= '0;
      entry_cnt <= entry_cnt + 1'b1;
    end else if ((state == HI) && phase_end) begin
      tx_shift  <= tx_shift << 1;
      bit_cnt   <= bit_cnt + 1'b1;
    end else if ((state == END) && phase_end) begin
      entry_cnt <= '0;
    end
  end

endmodule
